wb_master_ctrl: RTL and testbench

Wishbone initiator for the PWM/timer register block: turns single host commands (read/write, 16-bit address/data) into classic single Wishbone cycles toward the register slave.
Sits between a host-side sequencer/bridge and the slave's ctrl/divisor/period/DC registers.
Adds an ack timeout, an alignment check and a held response with its own handshake.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_timeout_cnt.sv | 42 ++++
 rtl/wb_master_ctrl.sv | 135 +++++++++++++
 tb/tb_wb_master_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the PWM/timer Wishbone path: FSM encodings, response
// error codes and register offsets used by master, slave and bench.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ALIGN   = 2'b10;

  localparam logic [15:0] REG_CTRL    = 16'h0000;
  localparam logic [15:0] REG_DIVISOR = 16'h0002;
  localparam logic [15:0] REG_PERIOD  = 16'h0004;
  localparam logic [15:0] REG_DC      = 16'h0006;

  // Registers are 16-bit and halfword aligned; an odd byte address is illegal.
  function automatic logic is_misaligned(input logic lsb);
    return lsb;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating ack-wait counter; expired flags the last permitted wait cycle.
module wb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stick at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = {CW{1'b0}};
    end else if (i_en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (cnt_q == CNT_LAST);

endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone classic single-cycle initiator for the PWM/timer register block,
// with ack timeout, alignment check and a held host response.
module wb_master_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 16
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_adr,
  input  logic [DW-1:0] i_cmd_data,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_data,
  output logic [1:0]    o_rsp_err,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_adr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_ack,
  input  logic [DW-1:0] i_wb_data
);

  wb_state_e     state_q;
  logic          cyc_q;
  logic          stb_q;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdata_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic [1:0]    rsp_err_q;

  logic cmd_accept_s;
  logic expired_s;

  assign o_cmd_ready  = (state_q == IDLE) && !i_wb_rst;
  assign cmd_accept_s = i_cmd_valid && o_cmd_ready;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .i_clk     (i_wb_clk),
    .i_rst     (i_wb_rst),
    .i_clr     (cmd_accept_s),
    .i_en      ((state_q == BUS) && !i_wb_ack),
    .o_expired (expired_s)
  );

  // Command/bus/response FSM; ack is only looked at while in BUS.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= {AW{1'b0}};
      wdata_q     <= {DW{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {DW{1'b0}};
      rsp_err_q   <= ERR_OK;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_cmd_valid) begin
            we_q    <= i_cmd_we;
            adr_q   <= i_cmd_adr;
            wdata_q <= i_cmd_data;
            if (is_misaligned(i_cmd_adr[0])) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= {DW{1'b0}};
              rsp_err_q   <= ERR_ALIGN;
              state_q     <= RESP;
            end else begin
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              state_q <= BUS;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        BUS: begin
          if (i_wb_ack) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= we_q ? {DW{1'b0}} : i_wb_data;
            rsp_err_q   <= ERR_OK;
            state_q     <= RESP;
          end else if (expired_s) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= {DW{1'b0}};
            rsp_err_q   <= ERR_TIMEOUT;
            state_q     <= RESP;
          end else begin
            state_q <= BUS;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            state_q <= RESP;
          end
        end
        default: begin
          cyc_q       <= 1'b0;
          stb_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_adr    = adr_q;
  assign o_wb_data   = wdata_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Bench for wb_master_ctrl: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_master_ctrl;
  import wb_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_we = 1'b0;
  logic [15:0] cmd_adr = 16'h0000;
  logic [15:0] cmd_data = 16'h0000;
  logic        rsp_ready = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] wb_rdata = 16'h0000;

  logic        cmd_ready, rsp_valid, wb_cyc, wb_stb, wb_we;
  logic [15:0] rsp_data, wb_adr, wb_wdata;
  logic [1:0]  rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_master_ctrl #(.TIMEOUT(TO), .DW(16), .AW(16)) dut (
    .i_wb_clk    (clk),
    .i_wb_rst    (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_we    (cmd_we),
    .i_cmd_adr   (cmd_adr),
    .i_cmd_data  (cmd_data),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_wb_cyc    (wb_cyc),
    .o_wb_stb    (wb_stb),
    .o_wb_we     (wb_we),
    .o_wb_adr    (wb_adr),
    .o_wb_data   (wb_wdata),
    .i_wb_ack    (ack),
    .i_wb_data   (wb_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a bus transfer in flight, or a response waiting.
  bit          m_busy = 1'b0;
  bit          m_pend = 1'b0;
  int          m_len = 0;
  logic        m_we = 1'b0;
  logic [15:0] m_adr = 16'h0000;
  logic [15:0] m_wd = 16'h0000;
  logic [15:0] m_rd = 16'h0000;
  logic [1:0]  m_err = 2'b00;
  int          cyc_run = 0;
  int          last_run = 0;
  int          cyc_total = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 1'b0; m_pend = 1'b0; m_len = 0;
        m_we = 1'b0; m_adr = 16'h0000; m_wd = 16'h0000;
        m_rd = 16'h0000; m_err = ERR_OK;
      end else if (m_pend) begin
        if (rsp_ready) m_pend = 1'b0;
      end else if (m_busy) begin
        m_len++;
        if (ack) begin
          m_busy = 1'b0; m_pend = 1'b1; m_err = ERR_OK;
          m_rd = m_we ? 16'h0000 : wb_rdata;
        end else if (m_len == TO) begin
          m_busy = 1'b0; m_pend = 1'b1; m_err = ERR_TIMEOUT; m_rd = 16'h0000;
        end
      end else if (cmd_valid) begin
        m_we = cmd_we; m_adr = cmd_adr; m_wd = cmd_data;
        if (cmd_adr[0]) begin
          m_pend = 1'b1; m_err = ERR_ALIGN; m_rd = 16'h0000;
        end else begin
          m_busy = 1'b1; m_len = 0;
        end
      end
      #1;
      chk("cmd_ready", cmd_ready, !m_busy && !m_pend && !rst);
      chk("wb_cyc", wb_cyc, m_busy);
      chk("wb_stb", wb_stb, m_busy);
      chk("wb_we", wb_we, m_we);
      chk("wb_adr", wb_adr, m_adr);
      chk("wb_data", wb_wdata, m_wd);
      chk("rsp_valid", rsp_valid, m_pend);
      if (m_pend) begin
        chk("rsp_data", rsp_data, m_rd);
        chk("rsp_err", rsp_err, m_err);
      end
      if (wb_cyc) begin
        cyc_run++;
        cyc_total++;
      end else if (cyc_run != 0) begin
        last_run = cyc_run;
        cyc_run = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [15:0] adr, input logic [15:0] data);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    chk("rsp_wait", rsp_valid, 1'b1);
  endtask

  task automatic release_rsp(input int delay);
    repeat (delay) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ready_back", cmd_ready, 1'b1);
    chk("rsp_dropped", rsp_valid, 1'b0);
  endtask

  int tot0;
  int mood;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cyc", wb_cyc, 1'b0);
    chk("rst_adr", wb_adr, 16'h0000);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_ready", cmd_ready, 1'b1);

    // Write, ack in second bus cycle.
    issue(1'b1, REG_DIVISOR, 16'h00FF);
    chk("wr_we", wb_we, 1'b1);
    chk("wr_adr", wb_adr, 16'h0002);
    chk("wr_data", wb_wdata, 16'h00FF);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("wr_valid", rsp_valid, 1'b1);
    chk("wr_err", rsp_err, 2'b00);
    chk("wr_rdata", rsp_data, 16'h0000);
    chk("wr_cyc_len", last_run, 2);
    release_rsp(0);

    // Read with ack in the first bus cycle.
    issue(1'b0, REG_DC, 16'h0000);
    ack = 1'b1; wb_rdata = 16'h1234;
    @(negedge clk);
    ack = 1'b0;
    chk("rd_data", rsp_data, 16'h1234);
    chk("rd_err", rsp_err, 2'b00);
    chk("rd_cyc_low", wb_cyc, 1'b0);
    chk("rd_cyc_len", last_run, 1);
    release_rsp(1);

    // Timeout.
    issue(1'b1, REG_PERIOD, 16'hA5A5);
    wait_rsp();
    chk("to_err", rsp_err, 2'b01);
    chk("to_data", rsp_data, 16'h0000);
    chk("to_cyc_len", last_run, 16);
    release_rsp(0);

    // Misaligned address.
    tot0 = cyc_total;
    issue(1'b0, 16'h0003, 16'h0000);
    chk("mis_valid", rsp_valid, 1'b1);
    chk("mis_err", rsp_err, 2'b10);
    chk("mis_no_cyc", cyc_total, tot0);
    release_rsp(0);

    // Backpressure with the slave holding ack.
    issue(1'b0, REG_CTRL, 16'h0000);
    ack = 1'b1; wb_rdata = 16'hBEEF;
    @(negedge clk);
    wb_rdata = 16'h0BAD;
    tot0 = cyc_total;
    repeat (5) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_data", rsp_data, 16'hBEEF);
      chk("bp_ready", cmd_ready, 1'b0);
      @(negedge clk);
    end
    chk("bp_no_cyc", cyc_total, tot0);
    ack = 1'b0;
    release_rsp(0);

    // Reset in the third bus cycle.
    issue(1'b1, REG_DIVISOR, 16'h1111);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_cyc", wb_cyc, 1'b0);
    chk("mrst_valid", rsp_valid, 1'b0);
    chk("mrst_adr", wb_adr, 16'h0000);
    rst = 1'b0;
    issue(1'b1, REG_DC, 16'h0042);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("post_rst_valid", rsp_valid, 1'b1);
    chk("post_rst_err", rsp_err, 2'b00);
    release_rsp(0);

    // Randomized traffic; slave responsiveness varies in phases.
    mood = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 64 == 0) mood = $urandom_range(0, 3);
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_we    = ($urandom_range(0, 1) == 1);
      cmd_adr   = 16'($urandom_range(0, 3) * 2);
      if ($urandom_range(0, 7) == 0) cmd_adr = 16'($urandom_range(0, 65535)) | 16'h0001;
      cmd_data  = 16'($urandom_range(0, 65535));
      wb_rdata  = 16'($urandom_range(0, 65535));
      rsp_ready = ($urandom_range(0, 4) < 2);
      case (mood)
        0: ack = 1'b0;
        1: ack = ($urandom_range(0, 9) == 0);
        2: ack = ($urandom_range(0, 2) == 0);
        default: ack = ($urandom_range(0, 9) != 0);
      endcase
      rst = ($urandom_range(0, 255) == 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0; ack = 1'b0; rst = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
